// File: rtl/seven_seg_defs.sv
// Shared constants for the board's seven-segment display blocks.
// Segment patterns are active-low: bit7 = dp, bits6..0 = g..a.
package seven_seg_defs;

   localparam logic [7:0] GLYPH_0 = 8'hC0;
   localparam logic [7:0] GLYPH_1 = 8'hF9;
   localparam logic [7:0] GLYPH_2 = 8'hA4;
   localparam logic [7:0] GLYPH_3 = 8'hB0;
   localparam logic [7:0] GLYPH_4 = 8'h99;
   localparam logic [7:0] GLYPH_5 = 8'h92;
   localparam logic [7:0] GLYPH_6 = 8'h82;
   localparam logic [7:0] GLYPH_7 = 8'hF8;
   localparam logic [7:0] GLYPH_8 = 8'h80;
   localparam logic [7:0] GLYPH_9 = 8'h90;
   localparam logic [7:0] GLYPH_A = 8'h88;
   localparam logic [7:0] GLYPH_B = 8'h83;
   localparam logic [7:0] GLYPH_C = 8'hC6;
   localparam logic [7:0] GLYPH_D = 8'hA1;
   localparam logic [7:0] GLYPH_E = 8'h86;
   localparam logic [7:0] GLYPH_F = 8'h8E;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam int         DP_BIT    = 7;

   // All anodes off; users slice the low NUM_DIGITS bits (up to AN_MAX digits).
   localparam int                AN_MAX = 64;
   localparam logic [AN_MAX-1:0] AN_OFF = {AN_MAX{1'b1}};

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (g..a).
module seven_seg_hex_decode
   import seven_seg_defs::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   // Glyph lookup
   always_comb begin
      segs = SEG_BLANK[6:0];
      case (nibble)
         4'h0: segs = GLYPH_0[6:0];
         4'h1: segs = GLYPH_1[6:0];
         4'h2: segs = GLYPH_2[6:0];
         4'h3: segs = GLYPH_3[6:0];
         4'h4: segs = GLYPH_4[6:0];
         4'h5: segs = GLYPH_5[6:0];
         4'h6: segs = GLYPH_6[6:0];
         4'h7: segs = GLYPH_7[6:0];
         4'h8: segs = GLYPH_8[6:0];
         4'h9: segs = GLYPH_9[6:0];
         4'hA: segs = GLYPH_A[6:0];
         4'hB: segs = GLYPH_B[6:0];
         4'hC: segs = GLYPH_C[6:0];
         4'hD: segs = GLYPH_D[6:0];
         4'hE: segs = GLYPH_E[6:0];
         4'hF: segs = GLYPH_F[6:0];
         default: segs = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Self-scanning multiplexed seven-segment driver with frame-latched inputs,
// blinking, leading-zero suppression and an anode guard interval.
module seven_seg_scan
   import seven_seg_defs::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [4*NUM_DIGITS-1:0] hex_data,
   input  logic [8*NUM_DIGITS-1:0] raw_data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    blank_lz,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   logic [BLK_W-1:0]        blk_cnt_r;
   logic                    phase_r;
   logic                    fresh_r;
   logic                    mode_sh_r;
   logic [4*NUM_DIGITS-1:0] hex_sh_r;
   logic [8*NUM_DIGITS-1:0] raw_sh_r;
   logic [NUM_DIGITS-1:0]   dp_sh_r;
   logic [NUM_DIGITS-1:0]   blink_sh_r;
   logic                    blank_lz_sh_r;
   logic [7:0]              seg_r;
   logic [NUM_DIGITS-1:0]   an_r;

   logic                    slot_end_s;
   logic                    frame_end_s;
   logic                    latch_s;
   logic [3:0]              nibble_s;
   logic [7:0]              raw_byte_s;
   logic [6:0]              glyph_s;
   logic                    zero_run_s;
   logic [NUM_DIGITS-1:0]   zero_above_s;
   logic                    lz_blank_s;
   logic [7:0]              seg_nxt_s;
   logic [NUM_DIGITS-1:0]   an_nxt_s;

   assign slot_end_s  = (cnt_r == CNT_LAST);
   assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);
   assign latch_s     = fresh_r || frame_end_s;
   assign nibble_s    = hex_sh_r[4*int'(idx_r) +: 4];
   assign raw_byte_s  = raw_sh_r[8*int'(idx_r) +: 8];

   seven_seg_hex_decode u_hex_decode (
      .nibble (nibble_s),
      .segs   (glyph_s)
   );

   // zero_above_s[i]: every nibble from the leftmost digit down to i is zero
   always_comb begin
      zero_run_s   = 1'b1;
      zero_above_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run_s      = zero_run_s && (hex_sh_r[4*i +: 4] == 4'h0);
         zero_above_s[i] = zero_run_s;
      end
   end

   assign lz_blank_s = blank_lz_sh_r && (idx_r != '0) && zero_above_s[idx_r];

   // Next-cycle segment/anode pattern for the current slot
   always_comb begin
      seg_nxt_s = SEG_BLANK;
      an_nxt_s  = AN_OFF[NUM_DIGITS-1:0];
      if (cnt_r < GUARD_CNT) begin
         seg_nxt_s = SEG_BLANK;
         an_nxt_s  = AN_OFF[NUM_DIGITS-1:0];
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt_s[i] = (idx_r != IDX_W'(i));
         end
         if (phase_r && blink_sh_r[idx_r]) begin
            seg_nxt_s = SEG_BLANK;
         end else if (mode_sh_r) begin
            seg_nxt_s = raw_byte_s;
         end else begin
            seg_nxt_s[DP_BIT] = ~dp_sh_r[idx_r];
            seg_nxt_s[6:0]    = lz_blank_s ? SEG_BLANK[6:0] : glyph_s;
         end
      end
   end

   // Scan counters, frame-latched shadows, blink phase and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r         <= '0;
         idx_r         <= '0;
         blk_cnt_r     <= '0;
         phase_r       <= 1'b0;
         fresh_r       <= 1'b1;
         mode_sh_r     <= 1'b0;
         hex_sh_r      <= '0;
         raw_sh_r      <= '0;
         dp_sh_r       <= '0;
         blink_sh_r    <= '0;
         blank_lz_sh_r <= 1'b0;
         seg_r         <= SEG_BLANK;
         an_r          <= AN_OFF[NUM_DIGITS-1:0];
      end else begin
         fresh_r <= 1'b0;
         seg_r   <= seg_nxt_s;
         an_r    <= an_nxt_s;
         if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (frame_end_s) begin
            if (blk_cnt_r == BLK_LAST) begin
               blk_cnt_r <= '0;
               phase_r   <= ~phase_r;
            end else begin
               blk_cnt_r <= blk_cnt_r + BLK_W'(1);
            end
         end
         // Shadows only move on a latch edge so a frame never tears
         if (latch_s) begin
            mode_sh_r     <= mode;
            hex_sh_r      <= hex_data;
            raw_sh_r      <= raw_data;
            dp_sh_r       <= dp;
            blink_sh_r    <= blink_mask;
            blank_lz_sh_r <= blank_lz;
         end
      end
   end

   assign seg = seg_r;
   assign an  = an_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (4 digits, 4-cycle slots, 1 guard cycle).
module tb_seven_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [15:0] hex_data;
   logic [31:0] raw_data;
   logic [3:0]  dp;
   logic [3:0]  blink_mask;
   logic        blank_lz;
   logic [7:0]  seg;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;
   logic [11:0] sb[$];

   always #5 clk = ~clk;

   seven_seg_scan #(
      .NUM_DIGITS   (4),
      .SCAN_DIV     (4),
      .GUARD        (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .hex_data   (hex_data),
      .raw_data   (raw_data),
      .dp         (dp),
      .blink_mask (blink_mask),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an)
   );

   // One frame = 16 cycles: per digit one dark cycle then three lit cycles.
   task automatic push_frame(input logic [7:0] g0, input logic [7:0] g1,
                             input logic [7:0] g2, input logic [7:0] g3);
      logic [7:0] g [4];
      logic [3:0] sel;
      g = '{g0, g1, g2, g3};
      for (int k = 0; k < 16; k++) begin
         if (k % 4 == 0) begin
            sb.push_back({4'b1111, 8'hFF});
         end else begin
            sel = 4'b0001 << (k / 4);
            sb.push_back({~sel, g[k / 4]});
         end
      end
   endtask

   task automatic set_inputs(input logic m, input logic [15:0] h, input logic [31:0] r,
                             input logic [3:0] d, input logic [3:0] b, input logic lz);
      mode = m; hex_data = h; raw_data = r; dp = d; blink_mask = b; blank_lz = lz;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      set_inputs(1'b0, 16'h1234, 32'h0, 4'b0000, 4'b0000, 1'b0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({an, seg} !== {4'b1111, 8'hFF}) begin
            failures++;
            $display("FAIL reset_hold cycle=%0d got an=%b seg=%h want an=1111 seg=ff", k, an, seg);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({an, seg} !== {4'b1111, 8'hFF}) begin
         failures++;
         $display("FAIL reset_release got an=%b seg=%h want an=1111 seg=ff", an, seg);
      end
   endtask

   task automatic test_hex_scan;
      logic [11:0] e;
      set_inputs(1'b0, 16'h1234, 32'h0, 4'b0000, 4'b0000, 1'b0);
      apply_reset(2);
      sb.delete();
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
      for (int k = 0; sb.size() > 0; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL hex_scan cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
      end
   endtask

   task automatic test_tear_free;
      logic [11:0] e;
      set_inputs(1'b0, 16'h1234, 32'h0, 4'b0000, 4'b0000, 1'b0);
      apply_reset(2);
      sb.delete();
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
      push_frame(8'hA1, 8'hC6, 8'h83, 8'h88);
      for (int k = 0; sb.size() > 0; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL tear_free cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
         if (k == 9) hex_data = 16'hABCD;
      end
   endtask

   task automatic test_lz_dp;
      logic [11:0] e;
      set_inputs(1'b0, 16'h0050, 32'h0, 4'b1000, 4'b0000, 1'b1);
      apply_reset(2);
      sb.delete();
      push_frame(8'hC0, 8'h92, 8'hFF, 8'h7F);
      push_frame(8'hC0, 8'h92, 8'hFF, 8'h7F);
      for (int k = 0; sb.size() > 0; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL lz_dp cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
      end
   endtask

   task automatic test_raw_blink;
      logic [11:0] e;
      // dp and blank_lz are set to show they have no effect in raw mode
      set_inputs(1'b1, 16'h0000, 32'h00FF55AA, 4'b1111, 4'b0001, 1'b1);
      apply_reset(2);
      sb.delete();
      push_frame(8'hAA, 8'h55, 8'hFF, 8'h00);
      push_frame(8'hAA, 8'h55, 8'hFF, 8'h00);
      push_frame(8'hFF, 8'h55, 8'hFF, 8'h00);
      push_frame(8'hFF, 8'h55, 8'hFF, 8'h00);
      push_frame(8'hAA, 8'h55, 8'hFF, 8'h00);
      for (int k = 0; sb.size() > 0; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL raw_blink cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
      end
   endtask

   task automatic test_midscan_reset;
      logic [11:0] e;
      set_inputs(1'b0, 16'h1234, 32'h0, 4'b0000, 4'b0000, 1'b0);
      apply_reset(2);
      sb.delete();
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL midscan_pre cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
      end
      sb.delete();
      rst = 1'b1;
      hex_data = 16'h5678;
      @(posedge clk); #1;
      checks++;
      if ({an, seg} !== {4'b1111, 8'hFF}) begin
         failures++;
         $display("FAIL midscan_reset got an=%b seg=%h want an=1111 seg=ff", an, seg);
      end
      rst = 1'b0;
      push_frame(8'h80, 8'hF8, 8'h82, 8'h92);
      for (int k = 0; sb.size() > 0; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({an, seg} !== e) begin
            failures++;
            $display("FAIL midscan_restart cycle=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, e[11:8], e[7:0]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_inputs(1'b0, 16'h0000, 32'h0, 4'b0000, 4'b0000, 1'b0);
      test_reset();
      test_hex_scan();
      test_tear_free();
      test_lz_dp();
      test_raw_blink();
      test_midscan_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
